dual_input_debouncer: RTL and testbench
=======================================

Name: dual_input_debouncer

Overview:
- Conditions two raw, bouncy one-bit inputs (switches/buttons) into clean, glitch-free levels a_db/b_db.
- These levels directly feed the downstream two-input combinational logic stage on its a and b inputs.
- Also produces a one-cycle rising-edge tick per channel for event-driven consumers.
- Each channel has a 2-FF synchronizer and an independent 4-state debounce FSM with a qualification counter.

Parameters:
- CNT_MAX, 1_000_000, consecutive synchronized-stable cycles required to accept a level change (10 ms at 100 MHz). Legal range 2 to 2^24. Benches override it to 4.
- CW, $clog2(CNT_MAX), counter width. Derived; do not override.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- a_raw  input  1  raw asynchronous input, channel A
- b_raw  input  1  raw asynchronous input, channel B
- a_db  output  1  debounced level A; feeds downstream a
- b_db  output  1  debounced level B; feeds downstream b
- a_tick  output  1  one-cycle pulse on accepted A 0->1 transition
- b_tick  output  1  one-cycle pulse on accepted B 0->1 transition

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset), sampled only on the rising edge of clk.
- Reset values:
  - Synchronizer flops: 0.
  - FSM state: ZERO.
  - Counter: 0.
  - a_db, b_db, a_tick, b_tick: 0.
- Synchronizer: x_raw -> ff1 -> ff2. Signal s = ff2. The FSM uses only s.
- The two channels are identical and fully independent. Simultaneous events on A and B are handled in parallel, with no interaction.
- FSM states: ZERO, WAIT1, ONE, WAIT0.
  - ZERO: if s=1, go to WAIT1 and set cnt=0.
  - WAIT1: if s=0, go to ZERO. Otherwise, if cnt==CNT_MAX-1, go to ONE. Otherwise cnt+=1.
  - ONE: if s=0, go to WAIT0 and set cnt=0.
  - WAIT0: if s=1, go to ONE. Otherwise, if cnt==CNT_MAX-1, go to ZERO. Otherwise cnt+=1.
- Any interruption while in a WAIT state restarts qualification from the stable state. There is no partial credit.
- Outputs:
  - x_db is a registered Moore output: 1 in ONE and WAIT0, 0 in ZERO and WAIT1.
  - x_tick is registered and is 1 for exactly the cycle in which x_db first reads 1 after the WAIT1->ONE transition.
  - There is no tick on the 1->0 transition.
- Latency, clean edge: raw first sampled high at edge E0 gives s=1 seen at edge E0+2. x_db and x_tick go high after edge E0+2+CNT_MAX, i.e. CNT_MAX+2 cycles.
  - Deassertion follows the same rule: x_db low after edge E0+2+CNT_MAX.
- Pulses shorter than CNT_MAX+1 consecutive s samples never change x_db.
- Counter never exceeds CNT_MAX-1. No wrap-around is possible.
- Reset mid-operation (in any state):
  - The next edge forces ZERO and x_db=0, even if x_raw is held high.
  - A held-high input then requalifies from scratch: x_db high CNT_MAX+2 cycles after reset deasserts.
  - A tick is generated on that requalification.
- Reset takes priority over all FSM transitions in the same cycle.
- Exactly one always block drives each output and each state/counter register. No variable is assigned from multiple processes.

Test Plan (CNT_MAX=4):
- Reset, raw held 0 for 20 cycles -> a_db=b_db=0, ticks never asserted.
- a_raw 0->1 clean step at edge E0, held -> a_db=1 and a_tick=1 after edge E0+6. a_tick=0 at E0+7. a_db stays 1. b channel unaffected.
- a_raw bounce 1,0,1,1,0,1 (one cycle each), then held 1 -> no a_db change during the bounce. a_db rises exactly 6 cycles after the final stable rise is sampled. Single a_tick.
- a_raw=1 and b_raw=1 on the same edge, then b_raw drops to 0 for one cycle at E0+3 -> a_db rises at E0+6. b_db rises 6 cycles after b_raw returns high. Two separate ticks.
- a_db=1, then a_raw drops at E1 with a 3-cycle glitch back to 1 -> a_db stays 1, no tick. Held low -> a_db=0 after E1+6.
- a_raw held 1 with a_db=1, reset pulsed for 1 cycle -> a_db=0 the next cycle. a_db and a_tick reassert 6 cycles after reset deasserts.

Source files
------------

// File: rtl/dual_input_debouncer.sv
// Dual-channel switch debouncer.
// Each channel passes through a 2-FF synchronizer. A 4-state FSM with a
// qualification counter then accepts a level change only after the
// synchronized input has held the new level for CNT_MAX+1 consecutive
// samples. Outputs are a clean level (x_db) and a one-cycle tick on each
// accepted rising transition (x_tick).
//
// state | meaning
// ------+-----------------------------------------------------------
// ZERO  | accepted level 0, input agrees
// WAIT1 | accepted level 0, input high, counting toward acceptance
// ONE   | accepted level 1, input agrees
// WAIT0 | accepted level 1, input low, counting toward acceptance

module dual_input_debouncer #(
  parameter int CNT_MAX = 1_000_000,
  parameter int CW      = $clog2(CNT_MAX)
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_db,
  output logic b_db,
  output logic a_tick,
  output logic b_tick
);

  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  // Channel 0 is A, channel 1 is B.
  logic [1:0]    w_raw;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  state_t        r_state [2];
  logic [CW-1:0] r_cnt   [2];
  logic [1:0]    r_db;
  logic [1:0]    r_tick;

  assign w_raw = {b_raw, a_raw};

  // Two-flop synchronizer for both raw inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-channel debounce FSM with registered level and tick outputs.
  // The level only changes on the WAIT->stable transitions, so it is
  // updated alongside those state changes instead of being decoded.
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (reset) begin
        r_state[ch] <= ZERO;
        r_cnt[ch]   <= '0;
        r_db[ch]    <= 1'b0;
        r_tick[ch]  <= 1'b0;
      end else begin
        r_tick[ch] <= 1'b0;
        case (r_state[ch])
          ZERO: begin
            if (r_sync2[ch]) begin
              r_state[ch] <= WAIT1;
              r_cnt[ch]   <= '0;
            end
          end
          WAIT1: begin
            if (!r_sync2[ch]) begin
              r_state[ch] <= ZERO;
            end else if (r_cnt[ch] == CNT_LAST) begin
              r_state[ch] <= ONE;
              r_db[ch]    <= 1'b1;
              r_tick[ch]  <= 1'b1;
            end else begin
              r_cnt[ch] <= r_cnt[ch] + CW'(1);
            end
          end
          ONE: begin
            if (!r_sync2[ch]) begin
              r_state[ch] <= WAIT0;
              r_cnt[ch]   <= '0;
            end
          end
          WAIT0: begin
            if (r_sync2[ch]) begin
              r_state[ch] <= ONE;
            end else if (r_cnt[ch] == CNT_LAST) begin
              r_state[ch] <= ZERO;
              r_db[ch]    <= 1'b0;
            end else begin
              r_cnt[ch] <= r_cnt[ch] + CW'(1);
            end
          end
          default: begin
            r_state[ch] <= ZERO;
            r_cnt[ch]   <= '0;
            r_db[ch]    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign a_db   = r_db[0];
  assign b_db   = r_db[1];
  assign a_tick = r_tick[0];
  assign b_tick = r_tick[1];

endmodule

// File: tb/tb_dual_input_debouncer.sv
// Bench for dual_input_debouncer with CNT_MAX=4: a cycle table of directed
// vectors, hand-written corner sequences, and a randomized run. Every step
// is also checked against a window-based reference model: a level change
// is accepted once the last CNT_MAX+1 synchronized samples all disagree
// with the current level.

module tb_dual_input_debouncer;

  localparam int CM = 4;

  logic clk = 1'b0;
  logic reset, a_raw, b_raw;
  logic a_db, b_db, a_tick, b_tick;

  int n_chk = 0;
  int n_err = 0;

  dual_input_debouncer #(.CNT_MAX(CM)) dut (
    .clk    (clk),
    .reset  (reset),
    .a_raw  (a_raw),
    .b_raw  (b_raw),
    .a_db   (a_db),
    .b_db   (b_db),
    .a_tick (a_tick),
    .b_tick (b_tick)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit m_p1   [2];
  bit m_p2   [2];
  bit m_db   [2];
  bit m_tick [2];
  bit m_win  [2][CM+1];
  int m_n    [2];

  task automatic model_edge(input bit rst, input bit a, input bit b);
    bit raw [2];
    bit s;
    bit all_diff;
    raw[0] = a;
    raw[1] = b;
    for (int ch = 0; ch < 2; ch++) begin
      if (rst) begin
        m_p1[ch] = 0; m_p2[ch] = 0; m_db[ch] = 0; m_tick[ch] = 0; m_n[ch] = 0;
      end else begin
        s = m_p2[ch];
        m_p2[ch] = m_p1[ch];
        m_p1[ch] = raw[ch];
        m_tick[ch] = 0;
        for (int i = CM; i > 0; i--) m_win[ch][i] = m_win[ch][i-1];
        m_win[ch][0] = s;
        if (m_n[ch] < CM + 1) m_n[ch]++;
        if (m_n[ch] == CM + 1) begin
          all_diff = 1;
          for (int i = 0; i <= CM; i++) if (m_win[ch][i] == m_db[ch]) all_diff = 0;
          if (all_diff) begin
            m_db[ch] = !m_db[ch];
            m_tick[ch] = m_db[ch];
          end
        end
      end
    end
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0b expected %0b", name, $time, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, clock once, check against model.
  task automatic step(input bit rst, input bit a, input bit b);
    @(negedge clk);
    reset = rst; a_raw = a; b_raw = b;
    @(posedge clk);
    model_edge(rst, a, b);
    #1;
    check("model a_db",   a_db,   m_db[0]);
    check("model b_db",   b_db,   m_db[1]);
    check("model a_tick", a_tick, m_tick[0]);
    check("model b_tick", b_tick, m_tick[1]);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit rst; bit a; bit b;
    bit adb; bit bdb; bit at; bit bt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int n, input bit rst, input bit a, input bit b,
                     input bit adb, input bit bdb, input bit at, input bit bt);
    vec_t v;
    v.rst = rst; v.a = a; v.b = b; v.adb = adb; v.bdb = bdb; v.at = at; v.bt = bt;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endtask

  initial begin
    int ticks;
    int hold [2];
    bit lvl [2];
    bit r;
    bit bounce [6];

    reset = 1; a_raw = 0; b_raw = 0;

    // rows: rst a b | a_db b_db a_tick b_tick
    add(2, 1,0,0, 0,0,0,0);
    add(1, 0,0,0, 0,0,0,0);
    add(6, 0,1,0, 0,0,0,0);   // a rises at row 3 (E0)
    add(1, 0,1,0, 1,0,1,0);   // E0+6
    add(1, 0,1,0, 1,0,0,0);
    add(6, 0,1,1, 1,0,0,0);   // b rises at row 11
    add(1, 0,1,1, 1,1,0,1);
    add(6, 0,0,1, 1,1,0,0);   // a falls at row 18
    add(1, 0,0,1, 0,1,0,0);   // falling edge gives no tick
    add(1, 1,0,1, 0,0,0,0);   // reset with b held high
    add(6, 0,0,1, 0,0,0,0);
    add(1, 0,0,1, 0,1,0,1);   // requalified with tick
    add(1, 0,0,1, 0,1,0,0);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].a, vq[i].b);
      check("tbl a_db",   a_db,   vq[i].adb);
      check("tbl b_db",   b_db,   vq[i].bdb);
      check("tbl a_tick", a_tick, vq[i].at);
      check("tbl b_tick", b_tick, vq[i].bt);
    end

    // Quiet both channels low.
    for (int i = 0; i < 12; i++) step(0, 0, 0);
    check("quiet a_db", a_db, 1'b0);
    check("quiet b_db", b_db, 1'b0);

    // Bounce 1,0,1,1,0,1 then held high; last bounce bit starts the run.
    bounce[0] = 1; bounce[1] = 0; bounce[2] = 1; bounce[3] = 1; bounce[4] = 0; bounce[5] = 1;
    ticks = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, bounce[i], 0);
      check("bounce a_db", a_db, 1'b0);
      ticks += int'(a_tick);
    end
    for (int k = 1; k <= 8; k++) begin
      step(0, 1, 0);
      check("bounce rise a_db",   a_db,   k >= 6);
      check("bounce rise a_tick", a_tick, k == 6);
      check("bounce b_db",        b_db,   1'b0);
      ticks += int'(a_tick);
    end
    check("bounce single tick", ticks == 1, 1'b1);

    // Simultaneous rise, b glitches low for one cycle at E0+3.
    for (int i = 0; i < 12; i++) step(0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      step(0, 1, k != 3);
      check("simul a_db",   a_db,   k >= 6);
      check("simul a_tick", a_tick, k == 6);
      check("simul b_db",   b_db,   k >= 10);
      check("simul b_tick", b_tick, k == 10);
    end

    // a high: 3-cycle low glitch is rejected, then a held low falls.
    for (int k = 0; k < 9; k++) begin
      step(0, k >= 3, 1);
      check("glitch a_db",   a_db,   1'b1);
      check("glitch a_tick", a_tick, 1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 1);
      check("fall a_db",   a_db,   k < 6);
      check("fall a_tick", a_tick, 1'b0);
    end

    // a held high and accepted, then a one-cycle reset pulse.
    for (int i = 0; i < 8; i++) step(0, 1, 1);
    check("pre-reset a_db", a_db, 1'b1);
    step(1, 1, 1);
    check("reset a_db", a_db, 1'b0);
    check("reset b_db", b_db, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      step(0, 1, 1);
      check("requal a_db",   a_db,   k >= 7);
      check("requal a_tick", a_tick, k == 7);
    end

    // Randomized run with held levels of random length and rare resets.
    hold[0] = 0; hold[1] = 0; lvl[0] = 0; lvl[1] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (hold[ch] == 0) begin
          lvl[ch]  = 1'($urandom_range(0, 1));
          hold[ch] = int'($urandom_range(1, 9));
        end
        hold[ch]--;
      end
      r = ($urandom_range(0, 199) == 0);
      step(r, lvl[0], lvl[1]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
